// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - exception/CSR handshake bundle for trap_controller
interface trap_controller_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic            misaligned_fetch;
  logic            illegal_instr;
  logic            ebreak;
  logic            ecall;
  logic            mret;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            trap_stall;
  logic            trapped;
  logic [XLEN-1:0] trap_target;

  // Trap sequencer side
  modport slave (
    input  pc, instr, misaligned_fetch, illegal_instr, ebreak, ecall, mret, csr_rdata,
    output csr_we, csr_addr, csr_wdata, trap_stall, trapped, trap_target
  );

  // Pipeline / CSR file side
  modport master (
    output pc, instr, misaligned_fetch, illegal_instr, ebreak, ecall, mret, csr_rdata,
    input  csr_we, csr_addr, csr_wdata, trap_stall, trapped, trap_target
  );
endinterface

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - M-mode trap sequencer (optional mtval write: TRAP_MTVAL_EN)
module trap_controller #(
  parameter int          XLEN        = 32,
  parameter logic [11:0] MTVEC_ADDR  = 12'h305,
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
  input logic              clk,
  input logic              reset,
  trap_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_R_MTVEC,
    S_R_MEPC,
    S_REDIRECT
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          r_state;
  logic [3:0]      r_cause;
  logic            r_csr_we;
  logic [11:0]     r_csr_addr;
  logic [XLEN-1:0] r_csr_wdata;
  logic            r_trapped;
  logic [XLEN-1:0] r_trap_target;

  logic            w_exc;
  logic            w_req;
  logic [3:0]      w_cause;

`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] w_tval;
`endif

  assign w_exc = bus.misaligned_fetch | bus.illegal_instr | bus.ebreak | bus.ecall;
  assign w_req = w_exc | bus.mret;

  // Highest-priority exception picks the cause code (and the mtval source)
  always_comb begin
    w_cause = 4'd0;
`ifdef TRAP_MTVAL_EN
    w_tval  = '0;
`endif
    if (bus.misaligned_fetch) begin
      w_cause = 4'd0;
`ifdef TRAP_MTVAL_EN
      w_tval  = bus.pc;
`endif
    end else if (bus.illegal_instr) begin
      w_cause = 4'd2;
`ifdef TRAP_MTVAL_EN
      w_tval  = XLEN'(bus.instr);
`endif
    end else if (bus.ebreak) begin
      w_cause = 4'd3;
    end else if (bus.ecall) begin
      w_cause = 4'd11;
    end
  end

  // The stall must cover the request cycle itself, so it cannot be registered
  assign bus.trap_stall  = (r_state != S_IDLE) | w_req;
  assign bus.csr_we      = r_csr_we;
  assign bus.csr_addr    = r_csr_addr;
  assign bus.csr_wdata   = r_csr_wdata;
  assign bus.trapped     = r_trapped;
  assign bus.trap_target = r_trap_target;

  // Sequencer; each output is loaded with the value it must show in the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cause       <= '0;
      r_csr_we      <= 1'b0;
      r_csr_addr    <= '0;
      r_csr_wdata   <= '0;
      r_trapped     <= 1'b0;
      r_trap_target <= '0;
`ifdef TRAP_MTVAL_EN
      r_tval        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_trapped     <= 1'b0;
          r_trap_target <= '0;
          if (w_exc) begin
            r_cause     <= w_cause;
`ifdef TRAP_MTVAL_EN
            r_tval      <= w_tval;
`endif
            r_csr_we    <= 1'b1;
            r_csr_addr  <= MEPC_ADDR;
            r_csr_wdata <= bus.pc;
            r_state     <= S_W_MEPC;
          end else if (bus.mret) begin
            r_csr_we    <= 1'b0;
            r_csr_addr  <= MEPC_ADDR;
            r_csr_wdata <= '0;
            r_state     <= S_R_MEPC;
          end else begin
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
          end
        end
        S_W_MEPC: begin
          r_csr_we    <= 1'b1;
          r_csr_addr  <= MCAUSE_ADDR;
          r_csr_wdata <= {{(XLEN-4){1'b0}}, r_cause};
          r_state     <= S_W_MCAUSE;
        end
        S_W_MCAUSE: begin
`ifdef TRAP_MTVAL_EN
          r_csr_we    <= 1'b1;
          r_csr_addr  <= MTVAL_ADDR;
          r_csr_wdata <= r_tval;
          r_state     <= S_W_MTVAL;
`else
          r_csr_we    <= 1'b0;
          r_csr_addr  <= MTVEC_ADDR;
          r_csr_wdata <= '0;
          r_state     <= S_R_MTVEC;
`endif
        end
        S_W_MTVAL: begin
          r_csr_we    <= 1'b0;
          r_csr_addr  <= MTVEC_ADDR;
          r_csr_wdata <= '0;
          r_state     <= S_R_MTVEC;
        end
        S_R_MTVEC, S_R_MEPC: begin
          // Direct mode only: the low two bits of the vector/return address are ignored
          r_csr_we      <= 1'b0;
          r_csr_addr    <= '0;
          r_csr_wdata   <= '0;
          r_trapped     <= 1'b1;
          r_trap_target <= bus.csr_rdata & ALIGN_MASK;
          r_state       <= S_REDIRECT;
        end
        S_REDIRECT: begin
          r_trapped     <= 1'b0;
          r_trap_target <= '0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_csr_we      <= 1'b0;
          r_csr_addr    <= '0;
          r_csr_wdata   <= '0;
          r_trapped     <= 1'b0;
          r_trap_target <= '0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
